// File: rtl/sprite_pkg.sv
// Shared constants, FSM state type and per-axis step helper for the sprite motion controller.
package sprite_pkg;

  localparam int unsigned SCREEN_W_DEF = 1280;
  localparam int unsigned SCREEN_H_DEF = 720;
  localparam int unsigned SPRITE_W_DEF = 256;
  localparam int unsigned SPRITE_H_DEF = 256;
  localparam int unsigned SPEED_W_DEF  = 4;

  localparam int unsigned MAX_X = SCREEN_W_DEF - SPRITE_W_DEF;
  localparam int unsigned MAX_Y = SCREEN_H_DEF - SPRITE_H_DEF;

  localparam int unsigned HCOUNT_W = 11;
  localparam int unsigned VCOUNT_W = 10;
  localparam int unsigned CALC_W   = 12;
  localparam int unsigned FRAME_W  = 16;

  typedef enum logic [1:0] {
    IDLE,
    CALC_X,
    CALC_Y,
    COMMIT
  } ctrl_state_t;

  typedef struct packed {
    logic [CALC_W-1:0] pos;
    logic              flip;
  } axis_step_t;

  // One frame of motion on one axis; landing on an edge reflects, a zero step never does.
  function automatic axis_step_t step_axis(
    input logic [CALC_W-1:0] pos,
    input logic [CALC_W-1:0] spd,
    input logic [CALC_W-1:0] max_pos,
    input logic              dir
  );
    axis_step_t      r;
    logic [CALC_W:0] sum;
    sum    = {1'b0, pos} + {1'b0, spd};
    r.pos  = pos;
    r.flip = 1'b0;
    if (spd != '0) begin
      if (dir) begin
        if (sum >= {1'b0, max_pos}) begin
          r.pos  = max_pos;
          r.flip = 1'b1;
        end else begin
          r.pos = sum[CALC_W-1:0];
        end
      end else if (pos <= spd) begin
        r.pos  = '0;
        r.flip = 1'b1;
      end else begin
        r.pos = pos - spd;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sprite_motion_ctrl_frame_tick_gen.sv
// Single-cycle start-of-vblank pulse; fires once per frame even if the raster counters stall.
module frame_tick_gen
  import sprite_pkg::*;
#(
  parameter int unsigned SCREEN_H = SCREEN_H_DEF
) (
  input  logic                pixel_clk_in,
  input  logic                rst_in,
  input  logic [HCOUNT_W-1:0] hcount_in,
  input  logic [VCOUNT_W-1:0] vcount_in,
  output logic                tick_c
);

  logic at_vblank_c;
  logic at_vblank_q;

  assign at_vblank_c = (hcount_in == '0) && (vcount_in == VCOUNT_W'(SCREEN_H));

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      at_vblank_q <= 1'b0;
    end else begin
      at_vblank_q <= at_vblank_c;
    end
  end

  // Rising edge of the vblank-start condition only.
  assign tick_c = at_vblank_c & ~at_vblank_q;

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Bouncing sprite position controller; all position changes commit during vertical blank.
module sprite_motion_ctrl
  import sprite_pkg::*;
#(
  parameter int unsigned SCREEN_W = SCREEN_W_DEF,
  parameter int unsigned SCREEN_H = SCREEN_H_DEF,
  parameter int unsigned SPRITE_W = SPRITE_W_DEF,
  parameter int unsigned SPRITE_H = SPRITE_H_DEF,
  parameter int unsigned SPEED_W  = SPEED_W_DEF
) (
  input  logic                pixel_clk_in,
  input  logic                rst_in,
  input  logic [HCOUNT_W-1:0] hcount_in,
  input  logic [VCOUNT_W-1:0] vcount_in,
  input  logic                enable_in,
  input  logic [SPEED_W-1:0]  speed_x_in,
  input  logic [SPEED_W-1:0]  speed_y_in,
  input  logic                load_valid_in,
  input  logic [HCOUNT_W-1:0] load_x_in,
  input  logic [VCOUNT_W-1:0] load_y_in,
  output logic                load_ready_out,
  output logic [HCOUNT_W-1:0] x_out,
  output logic [VCOUNT_W-1:0] y_out,
  output logic                dir_x_out,
  output logic                dir_y_out,
  output logic                bounce_out,
  output logic [FRAME_W-1:0]  frame_count_out
);

  localparam int unsigned LIM_X = SCREEN_W - SPRITE_W;
  localparam int unsigned LIM_Y = SCREEN_H - SPRITE_H;

  ctrl_state_t         state;
  logic                pending;
  logic [HCOUNT_W-1:0] load_x_q;
  logic [VCOUNT_W-1:0] load_y_q;
  logic                motion_en;
  axis_step_t          step_x;
  axis_step_t          step_y;

  logic                tick_c;
  logic                load_accept_c;
  logic [HCOUNT_W-1:0] load_x_clamp_c;
  logic [VCOUNT_W-1:0] load_y_clamp_c;

  frame_tick_gen #(
    .SCREEN_H (SCREEN_H)
  ) u_tick (
    .pixel_clk_in (pixel_clk_in),
    .rst_in       (rst_in),
    .hcount_in    (hcount_in),
    .vcount_in    (vcount_in),
    .tick_c       (tick_c)
  );

  assign load_ready_out = (state == IDLE) && !pending;
  assign load_accept_c  = load_valid_in && load_ready_out;

  assign load_x_clamp_c = (load_x_in > HCOUNT_W'(LIM_X)) ? HCOUNT_W'(LIM_X) : load_x_in;
  assign load_y_clamp_c = (load_y_in > VCOUNT_W'(LIM_Y)) ? VCOUNT_W'(LIM_Y) : load_y_in;

  // Control FSM and position datapath; x and y are stepped in separate cycles, then committed together.
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      state           <= IDLE;
      pending         <= 1'b0;
      load_x_q        <= '0;
      load_y_q        <= '0;
      motion_en       <= 1'b0;
      step_x          <= '0;
      step_y          <= '0;
      x_out           <= '0;
      y_out           <= '0;
      dir_x_out       <= 1'b1;
      dir_y_out       <= 1'b1;
      bounce_out      <= 1'b0;
      frame_count_out <= '0;
    end else begin
      bounce_out <= 1'b0;

      if (load_accept_c) begin
        pending  <= 1'b1;
        load_x_q <= load_x_clamp_c;
        load_y_q <= load_y_clamp_c;
      end

      case (state)
        IDLE: begin
          if (tick_c) begin
            state <= CALC_X;
          end
        end

        CALC_X: begin
          motion_en <= enable_in;
          step_x    <= step_axis(CALC_W'(x_out), CALC_W'(speed_x_in),
                                 CALC_W'(LIM_X), dir_x_out);
          state     <= CALC_Y;
        end

        CALC_Y: begin
          step_y <= step_axis(CALC_W'(y_out), CALC_W'(speed_y_in),
                              CALC_W'(LIM_Y), dir_y_out);
          state  <= COMMIT;
        end

        COMMIT: begin
          // A pending load wins over motion and never counts as a bounce.
          if (pending) begin
            x_out   <= load_x_q;
            y_out   <= load_y_q;
            pending <= 1'b0;
          end else if (motion_en) begin
            x_out      <= HCOUNT_W'(step_x.pos);
            y_out      <= VCOUNT_W'(step_y.pos);
            dir_x_out  <= dir_x_out ^ step_x.flip;
            dir_y_out  <= dir_y_out ^ step_y.flip;
            bounce_out <= step_x.flip | step_y.flip;
          end
          frame_count_out <= frame_count_out + FRAME_W'(1);
          state           <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed bench for sprite_motion_ctrl with a cycle-level behavioural model checked every cycle.
module tb_sprite_motion_ctrl;

  logic        pixel_clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [10:0] hcount_in = 11'd1;
  logic [9:0]  vcount_in = 10'd0;
  logic        enable_in = 1'b0;
  logic [3:0]  speed_x_in = 4'd0;
  logic [3:0]  speed_y_in = 4'd0;
  logic        load_valid_in = 1'b0;
  logic [10:0] load_x_in = 11'd0;
  logic [9:0]  load_y_in = 10'd0;
  logic        load_ready_out;
  logic [10:0] x_out;
  logic [9:0]  y_out;
  logic        dir_x_out;
  logic        dir_y_out;
  logic        bounce_out;
  logic [15:0] frame_count_out;

  sprite_motion_ctrl dut (
    .pixel_clk_in    (pixel_clk_in),
    .rst_in          (rst_in),
    .hcount_in       (hcount_in),
    .vcount_in       (vcount_in),
    .enable_in       (enable_in),
    .speed_x_in      (speed_x_in),
    .speed_y_in      (speed_y_in),
    .load_valid_in   (load_valid_in),
    .load_x_in       (load_x_in),
    .load_y_in       (load_y_in),
    .load_ready_out  (load_ready_out),
    .x_out           (x_out),
    .y_out           (y_out),
    .dir_x_out       (dir_x_out),
    .dir_y_out       (dir_y_out),
    .bounce_out      (bounce_out),
    .frame_count_out (frame_count_out)
  );

  always #5 pixel_clk_in = ~pixel_clk_in;

  int n_chk  = 0;
  int n_fail = 0;

  // Model state: position, direction, pending load, and cycles remaining until the commit.
  int mx, my, mlx, mly, mfc, msx, msy, cd;
  bit mdx, mdy, mb, mpend, men, mprev;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mx = 0; my = 0; mdx = 1'b1; mdy = 1'b1; mb = 1'b0;
    mpend = 1'b0; mfc = 0; cd = 0; mprev = 1'b0; men = 1'b0;
    mlx = 0; mly = 0; msx = 0; msy = 0;
  endtask

  task automatic move(inout int p, inout bit d, input int s, input int lim, output bit f);
    f = 1'b0;
    if (s == 0) return;
    if (d) begin
      if (p + s >= lim) begin p = lim; f = 1'b1; end
      else p = p + s;
    end else begin
      if (p <= s) begin p = 0; f = 1'b1; end
      else p = p - s;
    end
    if (f) d = ~d;
  endtask

  // Advance the model by one clock edge using the inputs that were stable before the edge.
  task automatic model_edge();
    bit cond, tick, ready, fx, fy;
    if (rst_in) begin
      model_reset();
      return;
    end
    cond  = (hcount_in == 11'd0) && (vcount_in == 10'd720);
    tick  = cond && !mprev;
    mprev = cond;
    ready = (cd == 0) && !mpend;
    mb    = 1'b0;
    if (load_valid_in && ready) begin
      mpend = 1'b1;
      mlx = (int'(load_x_in) > 1024) ? 1024 : int'(load_x_in);
      mly = (int'(load_y_in) > 464) ? 464 : int'(load_y_in);
    end
    if (cd == 0) begin
      if (tick) cd = 3;
    end else if (cd == 3) begin
      men = enable_in; msx = int'(speed_x_in); cd = 2;
    end else if (cd == 2) begin
      msy = int'(speed_y_in); cd = 1;
    end else begin
      if (mpend) begin
        mx = mlx; my = mly; mpend = 1'b0;
      end else if (men) begin
        move(mx, mdx, msx, 1024, fx);
        move(my, mdy, msy, 464, fy);
        mb = fx | fy;
      end
      mfc = (mfc + 1) % 65536;
      cd = 0;
    end
  endtask

  task automatic compare_all();
    chk("x_out", int'(x_out), mx);
    chk("y_out", int'(y_out), my);
    chk("dir_x_out", int'(dir_x_out), int'(mdx));
    chk("dir_y_out", int'(dir_y_out), int'(mdy));
    chk("bounce_out", int'(bounce_out), int'(mb));
    chk("frame_count_out", int'(frame_count_out), mfc);
    chk("load_ready_out", int'(load_ready_out), int'((cd == 0) && !mpend));
  endtask

  task automatic cycle();
    @(posedge pixel_clk_in);
    model_edge();
    #1;
    compare_all();
  endtask

  // Tick cycle T, then return at T+4 when the committed position is visible.
  task automatic tick_to_commit();
    hcount_in = 11'd0; vcount_in = 10'd720;
    cycle();
    hcount_in = 11'd1; vcount_in = 10'd721;
    repeat (3) cycle();
  endtask

  task automatic frame();
    tick_to_commit();
    repeat (4) cycle();
  endtask

  task automatic load(input int lx, input int ly);
    load_valid_in = 1'b1;
    load_x_in = 11'(lx);
    load_y_in = 10'(ly);
    cycle();
    load_valid_in = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (3) cycle();
    chk("reset x", int'(x_out), 0);
    chk("reset y", int'(y_out), 0);
    chk("reset dir_x", int'(dir_x_out), 1);
    chk("reset dir_y", int'(dir_y_out), 1);
    chk("reset frame_count", int'(frame_count_out), 0);
    chk("reset ready", int'(load_ready_out), 1);
    rst_in = 1'b0;
    repeat (2) cycle();

    // Basic motion, first frame checked for the four-cycle latency.
    enable_in = 1'b1; speed_x_in = 4'd4; speed_y_in = 4'd2;
    hcount_in = 11'd0; vcount_in = 10'd720;
    cycle();
    hcount_in = 11'd1; vcount_in = 10'd721;
    cycle(); cycle();
    chk("latency x at T+3", int'(x_out), 0);
    cycle();
    chk("latency x at T+4", int'(x_out), 4);
    chk("latency y at T+4", int'(y_out), 2);
    repeat (4) cycle();
    frame(); frame();
    chk("motion x", int'(x_out), 12);
    chk("motion y", int'(y_out), 6);
    chk("motion frames", int'(frame_count_out), 3);

    // Counters stalled at vblank start: only one frame advance.
    hcount_in = 11'd0; vcount_in = 10'd720;
    repeat (6) cycle();
    hcount_in = 11'd1; vcount_in = 10'd721;
    repeat (4) cycle();
    chk("stall x", int'(x_out), 16);
    chk("stall frames", int'(frame_count_out), 4);

    // Right-edge bounce.
    load(1022, 100);
    frame();
    chk("preload x", int'(x_out), 1022);
    tick_to_commit();
    chk("right edge x", int'(x_out), 1024);
    chk("right edge dir", int'(dir_x_out), 0);
    chk("right edge bounce", int'(bounce_out), 1);
    cycle();
    chk("bounce one cycle", int'(bounce_out), 0);
    repeat (3) cycle();
    frame();
    chk("after bounce x", int'(x_out), 1020);

    // Bottom bounce, then top bounce, then zero speed at the edge.
    speed_x_in = 4'd0; speed_y_in = 4'd5;
    load(500, 462);
    frame(); frame();
    chk("bottom y", int'(y_out), 464);
    chk("bottom dir", int'(dir_y_out), 0);
    load(500, 3);
    frame();
    tick_to_commit();
    chk("top y", int'(y_out), 0);
    chk("top dir", int'(dir_y_out), 1);
    chk("top bounce", int'(bounce_out), 1);
    repeat (4) cycle();
    speed_y_in = 4'd0;
    tick_to_commit();
    chk("zero speed y", int'(y_out), 0);
    chk("zero speed bounce", int'(bounce_out), 0);
    repeat (4) cycle();

    // Load accepted in the tick cycle, clamped; second load stalls until after commit.
    speed_x_in = 4'd3; speed_y_in = 4'd3;
    hcount_in = 11'd0; vcount_in = 10'd720;
    load_valid_in = 1'b1; load_x_in = 11'd2000; load_y_in = 10'd600;
    cycle();
    load_x_in = 11'd100; load_y_in = 10'd50;
    hcount_in = 11'd1; vcount_in = 10'd721;
    chk("busy ready", int'(load_ready_out), 0);
    repeat (3) cycle();
    chk("clamped x", int'(x_out), 1024);
    chk("clamped y", int'(y_out), 464);
    chk("load no bounce", int'(bounce_out), 0);
    chk("ready after commit", int'(load_ready_out), 1);
    cycle();
    load_valid_in = 1'b0;
    chk("pending ready", int'(load_ready_out), 0);
    repeat (3) cycle();
    frame();
    chk("second load x", int'(x_out), 100);
    chk("second load y", int'(y_out), 50);

    // Motion disabled: frozen position, frames still counted, loads still commit.
    enable_in = 1'b0; speed_x_in = 4'd4; speed_y_in = 4'd4;
    frame(); frame();
    chk("frozen x", int'(x_out), 100);
    chk("frozen y", int'(y_out), 50);
    chk("frozen frames", int'(frame_count_out), 16);
    load(300, 200);
    frame();
    chk("disabled load x", int'(x_out), 300);
    chk("disabled load y", int'(y_out), 200);
    chk("disabled load frames", int'(frame_count_out), 17);

    // Reset in CALC_Y with a load pending.
    enable_in = 1'b1;
    load(10, 10);
    hcount_in = 11'd0; vcount_in = 10'd720;
    cycle();
    hcount_in = 11'd1; vcount_in = 10'd721;
    cycle();
    #2 rst_in = 1'b1;
    #1;
    chk("midrst x", int'(x_out), 0);
    chk("midrst y", int'(y_out), 0);
    chk("midrst dir_x", int'(dir_x_out), 1);
    chk("midrst dir_y", int'(dir_y_out), 1);
    chk("midrst frames", int'(frame_count_out), 0);
    chk("midrst ready", int'(load_ready_out), 1);
    cycle();
    rst_in = 1'b0;
    repeat (2) cycle();
    frame();
    chk("post reset x", int'(x_out), 4);
    chk("post reset y", int'(y_out), 4);
    chk("post reset frames", int'(frame_count_out), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_motion_ctrl.md
Name: sprite_motion_ctrl

Overview:
Per-frame position controller for the 256x256 BRAM image sprite on the 1280x720 pixel pipeline. It produces the sprite's top-left x/y and moves it by a programmable speed once per frame, bouncing off the screen edges. It also accepts an external position-load request over a valid/ready handshake. All position updates are committed during vertical blank, so the sprite never tears mid-frame.

Parameters:
SCREEN_W, 1280, active horizontal pixels
SCREEN_H, 720, active vertical lines
SPRITE_W, 256, sprite width in pixels
SPRITE_H, 256, sprite height in pixels
SPEED_W, 4, width of the per-axis speed magnitude

Ports:
pixel_clk_in  input  1  pixel clock; the only clock
rst_in  input  1  asynchronous, active-high reset
hcount_in  input  11  current horizontal pixel count
vcount_in  input  10  current vertical line count
enable_in  input  1  1 = apply motion each frame; 0 = hold position
speed_x_in  input  SPEED_W  x step magnitude per frame
speed_y_in  input  SPEED_W  y step magnitude per frame
load_valid_in  input  1  request to load an absolute position
load_x_in  input  11  requested x
load_y_in  input  10  requested y
load_ready_out  output  1  load request can be accepted
x_out  output  11  sprite top-left x, fed to the sprite x_in
y_out  output  10  sprite top-left y, fed to the sprite y_in
dir_x_out  output  1  1 = moving right, 0 = moving left
dir_y_out  output  1  1 = moving down, 0 = moving up
bounce_out  output  1  one-cycle pulse when any axis reflected
frame_count_out  output  16  number of committed frames, wraps

Behaviour:
- Reset values (asynchronous, active-high):
  - x_out=0, y_out=0, dir_x_out=1, dir_y_out=1
  - bounce_out=0, frame_count_out=0
  - state IDLE, pending-load flag clear, so load_ready_out=1
- Constants: MAX_X = SCREEN_W-SPRITE_W = 1024; MAX_Y = SCREEN_H-SPRITE_H = 464.
- Frame tick: a one-cycle pulse in the cycle where hcount_in==0 and vcount_in==SCREEN_H (start of vblank).
  - The tick is edge-qualified: it fires at most once per frame even if the counters stall.
- FSM states: IDLE -> CALC_X -> CALC_Y -> COMMIT -> IDLE.
  - IDLE -> CALC_X on tick; each other transition is unconditional.
  - Tick seen at cycle T; new x_out/y_out are visible from T+4.
  - Ticks arriving outside IDLE are ignored. They cannot occur at legal video timing.
- Motion arithmetic:
  - Computed at 12 bits (x) and 11 bits (y); no truncation before the compare.
  - Right/down: if pos+speed >= MAX, pos=MAX and direction flips; otherwise pos += speed.
  - Left/up: if pos <= speed, pos=0 and direction flips; otherwise pos -= speed.
  - Landing exactly on an edge counts as a bounce.
  - speed=0 never bounces, even at an edge.
- Load handshake:
  - load_ready_out = (state==IDLE) && !pending.
  - Accept when load_valid_in && load_ready_out. Capture x/y clamped to MAX_X/MAX_Y and set pending.
  - At the next COMMIT, a pending load overrides motion on both axes. Directions are unchanged and pending clears.
  - Accept in the same cycle as the tick: that load is applied at this frame's COMMIT.
  - load_x_in/load_y_in are don't-care while valid is low.
  - Valid must stay high until accepted; the block does not check this.
- enable_in:
  - Sampled in CALC_X.
  - When 0, motion is skipped; a pending load still commits and frame_count still increments.
  - Speeds are sampled in CALC_X/CALC_Y respectively.
- bounce_out: high for exactly one cycle, the cycle after COMMIT, when either axis flipped. It is never asserted for load commits.
- frame_count_out increments at every COMMIT and wraps 0xFFFF -> 0.
- Reset mid-operation: all state returns to the reset values immediately; a pending load is discarded.

Decomposition:
- Package sprite_pkg:
  - SCREEN_W/H and SPRITE_W/H defaults
  - MAX_X/MAX_Y localparams
  - state enum ctrl_state_t {IDLE, CALC_X, CALC_Y, COMMIT}
- Sub-module frame_tick_gen:
  - Inputs: hcount/vcount, pixel_clk_in, rst_in.
  - Output: a single-cycle tick at the vblank start, with the once-per-frame qualification.

Test Plan:
- Reset, then enable=1, speed_x=4, speed_y=2, run 3 frames -> x_out 4,8,12; y_out 2,4,6; each change appears 4 cycles after the tick; frame_count_out=3.
- Preload x=1022, dir right, speed_x=4 -> next frame x_out=1024, dir_x_out=0, bounce_out pulses 1 cycle; following frame x_out=1020.
- Preload y=3, moving up, speed_y=5 -> y_out=0, dir_y_out=1, bounce pulse; speed_y=0 at y=0 -> no bounce, y stays 0.
- load_valid_in with x=2000, y=600 in the tick cycle -> accepted, x_out=1024, y_out=464 at T+4; a second load stalls (ready=0) until after COMMIT.
- enable=0 over 2 frames -> position is frozen, frame_count_out advances by 2; a load during this window still commits.
- Assert rst_in during CALC_Y with a load pending -> outputs return to reset values at once; after release, the next frame moves from (0,0).
